// File: rtl/irq_encoder.sv
// irq_encoder: pending-request latch plus a two-state grant FSM.
// Requests accumulate in a registered pending vector; one unmasked pending
// line is granted at a time. The grant is held stable until the consumer
// accepts it, then the line's pending bit is cleared.
// Build option: define IRQ_ENCODER_ROUND_ROBIN_EN for round-robin selection
// starting after the last accepted grant; otherwise the lowest index wins.
//
// state | meaning
// IDLE  | no grant outstanding, out_valid=0
// HOLD  | out_idx presented, out_valid=1, waiting for out_ready
module irq_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         any
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [N-1:0]   cand;
  logic [N-1:0]   clr;
  logic [W-1:0]   sel_idx;

`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0]   last_grant_q, last_grant_d;
  logic           sel_found;
`endif

  assign cand      = pending_q & ~mask;
  assign any       = |cand;
  assign out_valid = (state_q == HOLD);
  assign out_idx   = idx_q;
  assign pending   = pending_q;

`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
  // Pick the first unmasked pending line searching upward from last_grant+1, wrapping.
  always_comb begin
    logic [W-1:0] pos;
    sel_idx   = '0;
    sel_found = 1'b0;
    pos       = '0;
    for (int i = 0; i < N; i++) begin
      pos = last_grant_q + W'(1) + W'(i);
      if (!sel_found && cand[pos]) begin
        sel_found = 1'b1;
        sel_idx   = pos;
      end
    end
  end
`else
  // Pick the lowest-index unmasked pending line.
  always_comb begin
    sel_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) sel_idx = W'(i);
    end
  end
`endif

  // Grant FSM next state, grant index, handshake clear and pending update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr     = '0;
`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (any) begin
          idx_d   = sel_idx;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          clr[idx_q] = 1'b1;
          state_d    = IDLE;
`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
          last_grant_d = idx_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // A request arriving on its own clear edge keeps the bit set.
    pending_d = (pending_q & ~clr) | req;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
    end
  end

`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
  // Round-robin pointer; resets to N-1 so the first search begins at line 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= W'(N - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule

// File: tb/tb_irq_encoder.sv
// Directed bench for irq_encoder (N=8) with a behavioural reference model
// checked every cycle and literal grant-sequence expectations per scenario.
module tb_irq_encoder;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] mask = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic       any;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] m_pend = '0;
  logic       m_valid = 1'b0;
  logic [2:0] m_idx = '0;
  logic [2:0] m_last = 3'd7;

  int g_idx[$];
  int g_cyc[$];
  int exp_q[$];

  irq_encoder #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .pending(pending), .any(any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // First set bit of cand visited when walking upward from start+1 with wraparound.
  function automatic logic [2:0] pick(input logic [7:0] cand, input logic [2:0] start);
    logic [2:0] r;
    r = '0;
    for (int k = N; k >= 1; k--)
      if (cand[(int'(start) + k) % N]) r = 3'((int'(start) + k) % N);
    return r;
  endfunction

  // Reference model: pending set/clear rules plus one outstanding grant.
  always @(posedge clk or negedge rst_n) begin
    logic [7:0] nxt;
    logic [2:0] start;
    if (!rst_n) begin
      m_pend = '0; m_valid = 1'b0; m_idx = '0; m_last = 3'd7;
    end else begin
      nxt = m_pend;
      if (m_valid) begin
        if (out_ready) begin
          nxt[m_idx] = 1'b0;
          m_last = m_idx;
          m_valid = 1'b0;
        end
      end else if ((m_pend & ~mask) != 0) begin
`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
        start = m_last;
`else
        start = 3'd7;
`endif
        m_idx = pick(m_pend & ~mask, start);
        m_valid = 1'b1;
      end
      m_pend = nxt | req;
    end
  end

  // Per-cycle comparison against the model and grant recording.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) chk("out_idx", 32'(out_idx), 32'(m_idx));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("any", 32'(any), 32'(|(m_pend & ~mask)));
    if (out_valid && out_ready) begin
      g_idx.push_back(int'(out_idx));
      g_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_grants();
    g_idx.delete();
    g_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_grants(input string name);
    chk({name, "_count"}, 32'(g_idx.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < g_idx.size(); i++)
      chk({name, "_grant"}, 32'(g_idx[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_any", 32'(any), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Single request, handshake ready
    clear_grants();
    req = 8'h04; out_ready = 1'b1;
    step(1);
    req = 8'h00;
    chk("single_pend_set", 32'(pending), 32'h04);
    chk("single_not_yet", 32'(out_valid), 32'd0);
    step(1);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_idx", 32'(out_idx), 32'd2);
    step(1);
    chk("single_done_valid", 32'(out_valid), 32'd0);
    chk("single_done_pend", 32'(pending), 32'h00);
    exp_q = '{2};
    check_grants("single");
    step(2);

    // Three pending lines, continuous ready
    clear_grants();
    req = 8'h92;
    step(1);
    req = 8'h00;
    step(10);
`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
    exp_q = '{4, 7, 1};
`else
    exp_q = '{1, 4, 7};
`endif
    check_grants("prio");
    for (int i = 1; i < g_cyc.size(); i++)
      chk("prio_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd2);

    // Set wins over clear on the handshake edge
    clear_grants();
    out_ready = 1'b0; req = 8'h08;
    step(1);
    req = 8'h00;
    step(1);
    chk("setwin_hold_idx", 32'(out_idx), 32'd3);
    out_ready = 1'b1; req = 8'h08;
    step(1);
    req = 8'h00;
    chk("setwin_pend", 32'(pending), 32'h08);
    step(4);
    exp_q = '{3, 3};
    check_grants("setwin");

    // Masked line retained, granted once unmasked
    clear_grants();
    out_ready = 1'b0; mask = 8'h01; req = 8'h05;
    step(1);
    req = 8'h00;
    step(1);
    chk("mask_idx", 32'(out_idx), 32'd2);
    out_ready = 1'b1;
    step(1);
    chk("mask_retained", 32'(pending), 32'h01);
    chk("mask_any", 32'(any), 32'd0);
    step(3);
    chk("mask_idle", 32'(out_valid), 32'd0);
    mask = 8'h00;
    step(4);
    exp_q = '{2, 0};
    check_grants("mask");
    chk("mask_final_pend", 32'(pending), 32'h00);

    // Mask change during HOLD does not disturb the grant
    clear_grants();
    out_ready = 1'b0; req = 8'h30;
    step(1);
    req = 8'h00;
    step(1);
    mask = 8'hFF;
    step(2);
    chk("holdmask_valid", 32'(out_valid), 32'd1);
    chk("holdmask_idx", 32'(out_idx), 32'd4);
    out_ready = 1'b1;
    step(3);
    chk("allmasked_idle", 32'(out_valid), 32'd0);
    chk("allmasked_any", 32'(any), 32'd0);
    chk("allmasked_pend", 32'(pending), 32'h20);
    mask = 8'h00;
    step(4);
    exp_q = '{4, 5};
    check_grants("holdmask");

    // Asynchronous reset in the middle of HOLD on line 5
    out_ready = 1'b0; req = 8'h20;
    step(1);
    req = 8'h01;
    step(1);
    req = 8'h00;
    chk("prereset_idx", 32'(out_idx), 32'd5);
    chk("prereset_valid", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_pend", 32'(pending), 32'd0);
    chk("async_idx", 32'(out_idx), 32'd0);
    chk("async_any", 32'(any), 32'd0);
    req = 8'hFF;
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("post_reset_sample", 32'(pending), 32'hFF);
    chk("post_reset_valid", 32'(out_valid), 32'd0);

    // All lines requested after reset, then re-raise lines 0 and 1
    clear_grants();
    req = 8'h00; out_ready = 1'b1;
    step(18);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_grants("all");
    clear_grants();
    req = 8'h03;
    step(1);
    req = 8'h00;
    step(6);
    exp_q = '{0, 1};
    check_grants("reraise");
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
